relay_decode: RTL and testbench
===============================

Name: relay_decode

Overview:
- Receive-side counterpart of the relay line encoder: takes the single-wire relay pulse line and regenerates the original 16-clock-per-sample modulation stream.
- Mode 0: reader frames; each 128-clock relay symbol (high-first / high-second / all-low) maps back to an 8-sample pattern.
- Mode 1: tag data; each relay pulse becomes a fixed-length modulation burst.
- Sits between the relay link input and the FPGA modulation/output mux.

Parameters:
- SAMPLE_DIV, 16, clocks per regenerated sample.
- SYM_SAMPLES, 8, samples per relay symbol (window = SAMPLE_DIV*SYM_SAMPLES = 128 clk).
- TAG_PULSE, 64, clocks data_out is held high per tag-mode pulse.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = reader decode, 1 = tag decode.
- data_in  input  1  relay line from the link, already synchronised to clk.
- data_out  output  1  regenerated modulation sample stream.
- frame_active  output  1  high while a reader frame is being decoded.
- symbol_err  output  1  one-clock pulse on an illegal reader symbol.

Behaviour:
- Reset values:
  - data_out = 1 in mode 0, 0 in mode 1.
  - frame_active = 0, symbol_err = 0.
  - All counters and the pattern register clear.
- Reset overrides every other event in the same cycle, including mid-frame.
- Edge detect: a registered copy of data_in; rise = data_in & ~prev.
- Mode 0 FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - data_out = 1, win_cnt = 0.
  - On rise: go to RUN, set frame_active = 1, win_cnt = 0 in the next cycle. This rising edge is symbol 0's boundary; the first symbol of a frame is always high-first.
- RUN:
  - win_cnt is 7 bits and wraps 127 -> 0.
  - Sample h0 = data_in at win_cnt 32; sample h1 = data_in at win_cnt 96.
  - At win_cnt 127, classify the symbol and load the 8-bit out_pat (MSB played first):
    - h0=1, h1=0 -> 0x0F.
    - h0=0, h1=1 -> 0xF0.
    - h0=0, h1=0 -> 0xFF.
    - h0=1, h1=1 -> 0xFF, and symbol_err pulses the next cycle.
  - Playback: out_pat is shifted out one bit per SAMPLE_DIV clocks during the next window; data_out = current MSB. This gives exactly one window + 1 clock of latency from symbol start to first output sample.
  - End of frame: an all-low symbol immediately preceded by an all-low or high-first symbol. Load that symbol's pattern as normal, then go to FLUSH.
- FLUSH:
  - Finish playing out the 8 samples.
  - Then go to IDLE with frame_active = 0 and data_out = 1.
  - A rise during FLUSH is ignored.
- Mode 1:
  - On rise: data_out = 1 and pulse_cnt = TAG_PULSE-1, decrementing each clock; data_out = 0 when pulse_cnt reaches 0.
  - A rise while a pulse is active reloads pulse_cnt, extending the pulse.
  - frame_active stays 0.
- Mode change at any time: abort to IDLE / no pulse and load the new mode's idle data_out level next cycle; symbol_err is not asserted.
- Counter widths: win_cnt 7 bits, sample counter 4 bits, bit index 3 bits, pulse_cnt 8 bits. No saturation is needed; all counters wrap or reload as stated.

Decomposition:
- Shared package relay_pkg:
  - Symbol pattern constants PAT_HIGH_FIRST=0x0F, PAT_HIGH_SECOND=0xF0, PAT_ALL=0xFF.
  - Window sample offsets 32/96.
  - FSM state encoding (IDLE=0, RUN=1, FLUSH=2), reused by relay_encode updates.
- One natural sub-module, relay_pattern_player: 8-bit parallel load, SAMPLE_DIV-paced MSB-first shifter driving data_out.

Test Plan:
- Reset, mode 0, data_in held 0 for 500 clk -> data_out=1, frame_active=0, no symbol_err.
- Mode 0 frame: relay high 64 clk at t0, then 64 low, then window 2 with high at offsets 64..127, then two all-low windows.
  - Required data_out from t0+129: 0x0F, 0xF0, 0xFF, 0xFF, each bit held 16 clk.
  - frame_active falls after the last pattern completes; data_out then stays 1.
- Mode 0 illegal symbol: relay high a full 128 clk in window 1 -> symbol_err one-clock pulse at window-1 end +1; played pattern 0xFF.
- Mode 1: single 1-clk rise at t=10 -> data_out high t=11..74, low at 75.
  - A second rise at t=40 extends the high through t=104.
- Reset asserted at window offset 50 mid-frame -> next clk data_out=1, frame_active=0, counters 0.
  - A new rise is then accepted as a fresh frame start.
- Mode switched 0->1 mid-frame -> frame_active drops next clk, data_out=0, no symbol_err; tag pulses decode normally afterwards.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared definitions for the relay line encoder/decoder pair: timing
// constants, symbol patterns, window sample points and FSM state encoding.
package relay_pkg;

    localparam int SAMPLE_DIV  = 16;   // clocks per regenerated sample
    localparam int SYM_SAMPLES = 8;    // samples per relay symbol
    localparam int TAG_PULSE   = 64;   // clocks per tag-mode burst

    localparam logic [7:0] PAT_HIGH_FIRST  = 8'h0F;
    localparam logic [7:0] PAT_HIGH_SECOND = 8'hF0;
    localparam logic [7:0] PAT_ALL         = 8'hFF;

    // Sample points inside the 128-clock relay window
    localparam logic [6:0] WIN_H0_OFS = 7'd32;
    localparam logic [6:0] WIN_H1_OFS = 7'd96;
    localparam logic [6:0] WIN_LAST   = 7'd127;

    localparam logic [3:0] SMP_LAST   = 4'(SAMPLE_DIV - 1);
    localparam logic [2:0] BIT_LAST   = 3'(SYM_SAMPLES - 1);
    localparam logic [7:0] PULSE_LOAD = 8'(TAG_PULSE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } relay_state_e;

    // Map the two half-window samples of a relay symbol to its playback
    // pattern; the illegal both-high case also plays as all-ones.
    function automatic logic [7:0] symbol_pattern(input logic h0, input logic h1);
        logic [7:0] pat;
        case ({h0, h1})
            2'b10:   pat = PAT_HIGH_FIRST;
            2'b01:   pat = PAT_HIGH_SECOND;
            default: pat = PAT_ALL;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/relay_decode_if.sv
// Relay decoder signal bundle: relay line and mode in, regenerated
// modulation stream and frame status out.
interface relay_decode_if;

    logic mode;
    logic data_in;
    logic data_out;
    logic frame_active;
    logic symbol_err;

    modport master (
        output mode,
        output data_in,
        input  data_out,
        input  frame_active,
        input  symbol_err
    );

    modport slave (
        input  mode,
        input  data_in,
        output data_out,
        output frame_active,
        output symbol_err
    );

endinterface

// File: rtl/relay_pattern_player.sv
// Plays an 8-sample pattern MSB first, each sample held SAMPLE_DIV clocks.
// A new load may land on the final clock of the previous pattern so that
// back-to-back symbols play without a gap. Idle level is 1.
module relay_pattern_player
    import relay_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] pat,
    output logic       sample,
    output logic       done
);

    logic [6:0] shift_r;      // samples still to be played, next one in bit 6
    logic [3:0] smp_cnt_r;
    logic [2:0] bit_idx_r;
    logic       busy_r;
    logic       sample_r;
    logic       step_s;

    // A sample slot ends on the last clock of its SAMPLE_DIV period
    always_comb begin
        step_s = 1'b0;
        done   = 1'b0;
        if (busy_r && (smp_cnt_r == SMP_LAST)) begin
            step_s = 1'b1;
            done   = (bit_idx_r == BIT_LAST);
        end else begin
            step_s = 1'b0;
            done   = 1'b0;
        end
    end

    // Load, pace and shift the pattern; return to the idle level when done
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_r   <= 7'd0;
            smp_cnt_r <= 4'd0;
            bit_idx_r <= 3'd0;
            busy_r    <= 1'b0;
            sample_r  <= 1'b1;
        end else if (load) begin
            shift_r   <= pat[6:0];
            smp_cnt_r <= 4'd0;
            bit_idx_r <= 3'd0;
            busy_r    <= 1'b1;
            sample_r  <= pat[7];
        end else if (step_s) begin
            smp_cnt_r <= 4'd0;
            if (bit_idx_r == BIT_LAST) begin
                shift_r   <= 7'd0;
                bit_idx_r <= 3'd0;
                busy_r    <= 1'b0;
                sample_r  <= 1'b1;
            end else begin
                shift_r   <= {shift_r[5:0], 1'b0};
                bit_idx_r <= bit_idx_r + 3'd1;
                sample_r  <= shift_r[6];
            end
        end else if (busy_r) begin
            smp_cnt_r <= smp_cnt_r + 4'd1;
        end
    end

    assign sample = sample_r;

endmodule

// File: rtl/relay_decode.sv
// Relay line decoder. Mode 0 rebuilds reader frames from 128-clock relay
// symbols (one window + 1 clock latency); mode 1 stretches every relay
// pulse into a TAG_PULSE-clock modulation burst.
module relay_decode
    import relay_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    relay_decode_if.slave   bus
);

    logic         prev_r;
    logic         mode_r;
    relay_state_e state_r;
    relay_state_e state_next_s;
    logic [6:0]   win_cnt_r;
    logic         h0_r;
    logic         h1_r;
    logic         last_ok_r;       // previous symbol was all-low or high-first
    logic         frame_active_r;
    logic         symbol_err_r;
    logic         pulse_r;
    logic [7:0]   pulse_cnt_r;

    logic         rise_s;
    logic         mode_chg_s;
    logic         classify_s;
    logic         frame_end_s;
    logic [7:0]   pat_s;
    logic         play_sample_s;
    logic         play_done_s;

    assign rise_s      = bus.data_in & ~prev_r;
    assign mode_chg_s  = bus.mode ^ mode_r;
    assign frame_end_s = ~h0_r & ~h1_r & last_ok_r;
    assign pat_s       = symbol_pattern(h0_r, h1_r);

    // Edge-detect history and the mode seen on the previous clock
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= 1'b0;
            mode_r <= bus.mode;
        end else begin
            prev_r <= bus.data_in;
            mode_r <= bus.mode;
        end
    end

    // Reader-frame FSM next state; a mode change aborts whatever is running
    always_comb begin
        state_next_s = state_r;
        classify_s   = 1'b0;
        if (mode_chg_s) begin
            state_next_s = IDLE;
            classify_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_s && !mode_r) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                RUN: begin
                    if (win_cnt_r == WIN_LAST) begin
                        classify_s = 1'b1;
                        if (frame_end_s) begin
                            state_next_s = FLUSH;
                        end else begin
                            state_next_s = RUN;
                        end
                    end else begin
                        state_next_s = RUN;
                    end
                end
                FLUSH: begin
                    if (play_done_s) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = FLUSH;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Frame state, window counter, half-window samples and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            win_cnt_r      <= 7'd0;
            h0_r           <= 1'b0;
            h1_r           <= 1'b0;
            last_ok_r      <= 1'b0;
            frame_active_r <= 1'b0;
            symbol_err_r   <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            frame_active_r <= (state_next_s != IDLE);
            symbol_err_r   <= classify_s & h0_r & h1_r;

            if (state_next_s == IDLE || state_r == IDLE) begin
                win_cnt_r <= 7'd0;
            end else begin
                win_cnt_r <= win_cnt_r + 7'd1;
            end

            if (state_r == RUN && win_cnt_r == WIN_H0_OFS) begin
                h0_r <= bus.data_in;
            end
            if (state_r == RUN && win_cnt_r == WIN_H1_OFS) begin
                h1_r <= bus.data_in;
            end

            if (state_r == IDLE) begin
                last_ok_r <= 1'b0;
            end else if (classify_s) begin
                last_ok_r <= ~h1_r;
            end
        end
    end

    // Tag-mode burst: each rise (re)loads the down-counter and raises the line
    always_ff @(posedge clk) begin
        if (reset || mode_chg_s || !mode_r) begin
            pulse_r     <= 1'b0;
            pulse_cnt_r <= 8'd0;
        end else if (rise_s) begin
            pulse_r     <= 1'b1;
            pulse_cnt_r <= PULSE_LOAD;
        end else if (pulse_r) begin
            if (pulse_cnt_r == 8'd0) begin
                pulse_r <= 1'b0;
            end else begin
                pulse_cnt_r <= pulse_cnt_r - 8'd1;
            end
        end
    end

    relay_pattern_player u_player (
        .clk    (clk),
        .reset  (reset),
        .clear  (mode_chg_s),
        .load   (classify_s),
        .pat    (pat_s),
        .sample (play_sample_s),
        .done   (play_done_s)
    );

    assign bus.data_out     = mode_r ? pulse_r : play_sample_s;
    assign bus.frame_active = frame_active_r;
    assign bus.symbol_err   = symbol_err_r;

endmodule

// File: tb/tb_relay_decode.sv
// Bench for relay_decode: builds a stimulus trace (directed segments plus
// $urandom frames and tag pulses), steps a frame-level reference model
// alongside the DUT, and checks every output every clock, followed by
// spot checks at the notable instants of the directed segments.
module tb_relay_decode;

    localparam int N_MAX = 16384;

    logic clk = 1'b0;
    logic reset;

    relay_decode_if u_if ();

    relay_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    logic din_a  [N_MAX];
    logic mode_a [N_MAX];
    logic rst_a  [N_MAX];
    logic obs_do [N_MAX];
    logic obs_fa [N_MAX];
    logic obs_se [N_MAX];
    int   n_len;
    logic cur_mode;
    int   total_cnt;
    int   bad_cnt;

    task automatic check_val(input string tag, input int p, input logic obs, input logic exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s @%0d: got %0b expected %0b", tag, p, obs, exp);
        end
    endtask

    task automatic put(input logic d, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (n_len < N_MAX) begin
                din_a[n_len]  = d;
                mode_a[n_len] = cur_mode;
                rst_a[n_len]  = 1'b0;
                n_len++;
            end
        end
    endtask

    // kind: 0 high-first, 1 high-second, 2 all-low, 3 illegal all-high
    task automatic sym(input int kind);
        for (int off = 0; off < 128; off++) begin
            logic d;
            case (kind)
                0:       d = (off < 64);
                1:       d = (off >= 64);
                3:       d = 1'b1;
                default: d = 1'b0;
            endcase
            put(d, 1);
        end
    endtask

    // Reference model state
    logic       m_mode;
    bit         infr;
    int         t0;
    int         end_sym;
    bit         last_ok;
    int         pulse_end;
    logic [7:0] pats [64];

    int t_fr, t_il, t_rs0, t_rst, t_ms0, t_sw, t_tag;

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        n_len     = 0;
        cur_mode  = 1'b0;
        reset        = 1'b1;
        u_if.mode    = 1'b0;
        u_if.data_in = 1'b0;

        // ---- build the trace ----
        put(1'b0, 5);
        for (int i = 0; i < 5; i++) rst_a[i] = 1'b1;
        put(1'b0, 500);
        // directed frame: HF, HS, AL, AL
        put(1'b0, 20);
        t_fr = n_len;
        sym(0); sym(1); sym(2); sym(2);
        put(1'b0, 200);
        // illegal first symbol
        t_il = n_len;
        sym(3); sym(2); sym(2);
        put(1'b0, 200);
        // random frames
        for (int f = 0; f < 4; f++) begin
            int ns;
            put(1'b0, int'($urandom_range(150, 220)));
            sym(0);
            ns = int'($urandom_range(1, 4));
            for (int s = 0; s < ns; s++) sym(int'($urandom_range(0, 3)));
            sym(2); sym(2);
        end
        put(1'b0, 200);
        // reset at offset 50 of window 1, then a fresh frame from the next rise
        t_rs0 = n_len;
        sym(0);
        t_rst = n_len + 50;
        sym(1);
        rst_a[t_rst] = 1'b1;
        put(1'b0, 64);
        sym(1); sym(2); sym(2);
        put(1'b0, 200);
        // mode 0 -> 1 mid-frame, then random tag pulses
        t_ms0 = n_len;
        sym(0);
        put(1'b0, 80);
        cur_mode = 1'b1;
        t_sw = n_len;
        put(1'b0, 30);
        for (int i = 0; i < 12; i++) begin
            put(1'b1, int'($urandom_range(1, 4)));
            put(1'b0, int'($urandom_range(5, 90)));
        end
        // directed tag pulses at +10 and +40
        put(1'b0, 100);
        t_tag = n_len;
        put(1'b0, 10); put(1'b1, 1); put(1'b0, 29); put(1'b1, 1); put(1'b0, 100);
        // back to reader mode and one more random frame
        cur_mode = 1'b0;
        put(1'b0, 50);
        sym(0); sym(int'($urandom_range(0, 3))); sym(int'($urandom_range(0, 3))); sym(2); sym(2);
        put(1'b0, 200);

        // ---- run DUT and model together ----
        infr      = 1'b0;
        m_mode    = 1'b0;
        pulse_end = -1;
        end_sym   = -1;
        last_ok   = 1'b0;
        t0        = 0;
        for (int p = 0; p < n_len; p++) begin
            logic prev_in, rise, e_do, e_fa, e_se;
            @(negedge clk);
            reset        = rst_a[p];
            u_if.mode    = mode_a[p];
            u_if.data_in = din_a[p];
            @(posedge clk);
            #1;
            obs_do[p] = u_if.data_out;
            obs_fa[p] = u_if.frame_active;
            obs_se[p] = u_if.symbol_err;

            prev_in = (p == 0 || rst_a[p-1]) ? 1'b0 : din_a[p-1];
            rise    = din_a[p] & ~prev_in;
            e_se    = 1'b0;
            e_fa    = 1'b0;
            e_do    = 1'b1;
            if (rst_a[p] || mode_a[p] != m_mode) begin
                m_mode    = mode_a[p];
                infr      = 1'b0;
                pulse_end = -1;
                e_do      = ~mode_a[p];
            end else if (m_mode) begin
                if (rise) pulse_end = p + 63;
                e_do = (p <= pulse_end);
            end else begin
                if (!infr && rise) begin
                    infr    = 1'b1;
                    t0      = p;
                    end_sym = -1;
                    last_ok = 1'b0;
                end
                if (infr) begin
                    int d, w;
                    d = p - t0;
                    w = d / 128;
                    if (end_sym >= 0 && w == end_sym + 2) begin
                        infr = 1'b0;
                    end else begin
                        if (d > 0 && d % 128 == 0 && end_sym < 0) begin
                            int k;
                            logic h0, h1;
                            k  = w - 1;
                            h0 = din_a[t0 + 128*k + 33];
                            h1 = din_a[t0 + 128*k + 97];
                            pats[k % 64] = (h0 && !h1) ? 8'h0F : ((!h0 && h1) ? 8'hF0 : 8'hFF);
                            e_se = h0 & h1;
                            if (!h0 && !h1 && last_ok) end_sym = k;
                            last_ok = !h1;
                        end
                        e_fa = 1'b1;
                        if (w == 0) begin
                            e_do = 1'b1;
                        end else begin
                            logic [7:0] pt;
                            pt   = pats[(w - 1) % 64];
                            e_do = pt[7 - (d % 128) / 16];
                        end
                    end
                end
            end
            check_val("data_out", p, obs_do[p], e_do);
            check_val("frame_active", p, obs_fa[p], e_fa);
            check_val("symbol_err", p, obs_se[p], e_se);
        end

        // ---- spot checks at the directed instants ----
        check_val("idle_out", 300, obs_do[300], 1'b1);
        check_val("idle_fa", 300, obs_fa[300], 1'b0);
        check_val("fr_prelat", t_fr+127, obs_do[t_fr+127], 1'b1);
        check_val("fr_p0_first", t_fr+128, obs_do[t_fr+128], 1'b0);
        check_val("fr_p0_b3", t_fr+191, obs_do[t_fr+191], 1'b0);
        check_val("fr_p0_b4", t_fr+192, obs_do[t_fr+192], 1'b1);
        check_val("fr_p1_b0", t_fr+256, obs_do[t_fr+256], 1'b1);
        check_val("fr_p1_b4", t_fr+320, obs_do[t_fr+320], 1'b0);
        check_val("fr_p2", t_fr+400, obs_do[t_fr+400], 1'b1);
        check_val("fr_active_last", t_fr+639, obs_fa[t_fr+639], 1'b1);
        check_val("fr_active_fall", t_fr+640, obs_fa[t_fr+640], 1'b0);
        check_val("fr_out_after", t_fr+640, obs_do[t_fr+640], 1'b1);
        check_val("il_err_pre", t_il+127, obs_se[t_il+127], 1'b0);
        check_val("il_err", t_il+128, obs_se[t_il+128], 1'b1);
        check_val("il_err_post", t_il+129, obs_se[t_il+129], 1'b0);
        check_val("il_pat", t_il+200, obs_do[t_il+200], 1'b1);
        check_val("il_active_fall", t_il+512, obs_fa[t_il+512], 1'b0);
        check_val("rst_fa_pre", t_rst-1, obs_fa[t_rst-1], 1'b1);
        check_val("rst_fa", t_rst, obs_fa[t_rst], 1'b0);
        check_val("rst_out", t_rst, obs_do[t_rst], 1'b1);
        check_val("rst_new_idle", t_rst+13, obs_fa[t_rst+13], 1'b0);
        check_val("rst_new_frame", t_rst+14, obs_fa[t_rst+14], 1'b1);
        check_val("sw_fa_pre", t_sw-1, obs_fa[t_sw-1], 1'b1);
        check_val("sw_out_pre", t_sw-1, obs_do[t_sw-1], 1'b1);
        check_val("sw_fa", t_sw, obs_fa[t_sw], 1'b0);
        check_val("sw_out", t_sw, obs_do[t_sw], 1'b0);
        check_val("sw_err", t_sw, obs_se[t_sw], 1'b0);
        check_val("tag_pre", t_tag+9, obs_do[t_tag+9], 1'b0);
        check_val("tag_rise", t_tag+10, obs_do[t_tag+10], 1'b1);
        check_val("tag_ext", t_tag+74, obs_do[t_tag+74], 1'b1);
        check_val("tag_last", t_tag+103, obs_do[t_tag+103], 1'b1);
        check_val("tag_fall", t_tag+104, obs_do[t_tag+104], 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
